// File: rtl/bus_fabric.sv
// Round-robin N-master / M-slave bus fabric with base/mask decode.
// Optional stall watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_fabric #(
    parameter int              NM         = 2,
    parameter int              NS         = 11,
    parameter int              AW         = 32,
    parameter int              DW         = 32,
    parameter logic [NS*AW-1:0] SLAVE_BASE = '0,
    parameter logic [NS*AW-1:0] SLAVE_MASK = '0,
    parameter int              TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NM-1:0]        m_read,
    input  logic [NM-1:0]        m_write,
    input  logic [NM*AW-1:0]     m_address,
    input  logic [NM*DW-1:0]     m_writedata,
    input  logic [NM*DW/8-1:0]   m_be,
    output logic [NM-1:0]        m_wait,
    output logic [DW-1:0]        m_readdata,
    output logic [NS-1:0]        s_read,
    output logic [NS-1:0]        s_write,
    output logic [AW-1:0]        s_address,
    output logic [DW-1:0]        s_writedata,
    output logic [DW/8-1:0]      s_be,
    input  logic [NS*DW-1:0]     s_readdata,
    input  logic [NS-1:0]        s_wait,
    output logic                 bus_error,
    output logic [NM-1:0]        grant
);

    localparam int BW = DW / 8;
    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [GW-1:0] r_last;
    logic [GW-1:0] r_gidx;
    logic [NM-1:0] r_grant;
    logic [SW-1:0] r_sel;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [BW-1:0] r_be;
    logic [DW-1:0] r_rdata;
    logic [NS-1:0] r_sread;
    logic [NS-1:0] r_swrite;
    logic          r_err;

    logic [NM-1:0] w_req;
    logic          w_any;
    logic [GW-1:0] w_pick;
    logic [AW-1:0] w_maddr;
    logic          w_hit;
    logic [SW-1:0] w_hsel;
    logic          w_sw;
    logic [DW-1:0] w_srd;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [DW-1:0] DEAD = DW'(32'hDEADDEAD);
    logic [CW-1:0] r_cnt;
`endif

    assign w_req = m_read | m_write;
    assign w_any = |w_req;

    // Search starts just after the last served master.
    always_comb begin
        int v;
        logic found;
        w_pick = '0;
        found  = 1'b0;
        for (int k = 1; k <= NM; k++) begin
            v = (int'(r_last) + k) % NM;
            if (!found && w_req[GW'(v)]) begin
                found  = 1'b1;
                w_pick = GW'(v);
            end
        end
    end

    assign w_maddr = m_address[w_pick*AW +: AW];

    // Descending scan so the lowest matching window wins.
    always_comb begin
        w_hit  = 1'b0;
        w_hsel = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((w_maddr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
                w_hit  = 1'b1;
                w_hsel = SW'(i);
            end
        end
    end

    assign w_sw  = s_wait[r_sel];
    assign w_srd = s_readdata[r_sel*DW +: DW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_last   <= GW'(NM - 1);
            r_gidx   <= '0;
            r_grant  <= '0;
            r_sel    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rdata  <= '0;
            r_sread  <= '0;
            r_swrite <= '0;
            r_err    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gidx  <= w_pick;
                        r_grant <= NM'(1) << w_pick;
                        r_addr  <= w_maddr;
                        r_wdata <= m_writedata[w_pick*DW +: DW];
                        r_be    <= m_be[w_pick*BW +: BW];
                        if (w_hit) begin
                            r_sel <= w_hsel;
                            if (m_write[w_pick])
                                r_swrite <= NS'(1) << w_hsel;
                            else
                                r_sread <= NS'(1) << w_hsel;
                            r_state <= S_XFER;
`ifdef BUS_TIMEOUT_EN
                            r_cnt <= '0;
`endif
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_XFER: begin
                    if (!w_sw) begin
                        r_rdata  <= w_srd;
                        r_sread  <= '0;
                        r_swrite <= '0;
                        r_state  <= S_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rdata  <= DEAD;
                        r_sread  <= '0;
                        r_swrite <= '0;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_last  <= r_gidx;
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        m_wait = '1;
        if (r_state == S_DONE)
            m_wait = ~r_grant;
    end

    assign m_readdata  = r_rdata;
    assign s_read      = r_sread;
    assign s_write     = r_swrite;
    assign s_address   = r_addr;
    assign s_writedata = r_wdata;
    assign s_be        = r_be;
    assign bus_error   = r_err;
    assign grant       = r_grant;

endmodule
